// File: rtl/traffic_light_fsm.sv
// Main sequencing FSM of the traffic controller: arms the Timer per state and drives the lamps.
// Optional side-street green extension state is built only when TRAFFIC_SIDE_EXT_EN is defined.
module traffic_light_fsm #(
    parameter logic [1:0] IDX_BASE = 2'd0,
    parameter logic [1:0] IDX_EXT  = 2'd1,
    parameter logic [1:0] IDX_YEL  = 2'd2
) (
    input  logic       clk,
    input  logic       sys_reset,
    input  logic       sensor_sync,
    input  logic       WR,
    input  logic       prog_sync,
    input  logic       expired,
    output logic [1:0] interval,
    output logic       start_timer,
    output logic       WR_reset,
    output logic       Rm,
    output logic       Ym,
    output logic       Gm,
    output logic       Rs,
    output logic       Ys,
    output logic       Gs,
    output logic       W
);

    localparam logic [2:0] S_G_MAIN_A = 3'd0;
    localparam logic [2:0] S_G_MAIN_B = 3'd1;
    localparam logic [2:0] S_Y_MAIN   = 3'd2;
    localparam logic [2:0] S_WALK     = 3'd3;
    localparam logic [2:0] S_G_SIDE   = 3'd4;
    localparam logic [2:0] S_G_SIDE_X = 3'd5;
    localparam logic [2:0] S_Y_SIDE   = 3'd6;

    // Lamp vector layout: {Rm, Ym, Gm, Rs, Ys, Gs, W}
    localparam logic [6:0] L_GREEN_MAIN  = 7'b0011000;
    localparam logic [6:0] L_YELLOW_MAIN = 7'b0101000;
    localparam logic [6:0] L_WALK        = 7'b1001001;
    localparam logic [6:0] L_GREEN_SIDE  = 7'b1000010;
    localparam logic [6:0] L_YELLOW_SIDE = 7'b1000100;

    logic [2:0] state_q, state_d;
    logic       pend_q, pend_d;
    logic       start_q, start_d;
    logic       wrr_q, wrr_d;
    logic [1:0] interval_q, interval_d;
    logic [6:0] lamps_q, lamps_d;

    function automatic logic state_legal(input logic [2:0] s);
        logic ok;
        case (s)
            S_G_MAIN_A, S_G_MAIN_B, S_Y_MAIN, S_WALK,
            S_G_SIDE, S_Y_SIDE: ok = 1'b1;
`ifdef TRAFFIC_SIDE_EXT_EN
            S_G_SIDE_X:         ok = 1'b1;
`endif
            default:            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [1:0] state_interval(input logic [2:0] s);
        logic [1:0] idx;
        case (s)
            S_Y_MAIN, S_Y_SIDE:   idx = IDX_YEL;
            S_WALK, S_G_SIDE_X:   idx = IDX_EXT;
            default:              idx = IDX_BASE;
        endcase
        return idx;
    endfunction

    function automatic logic [6:0] state_lamps(input logic [2:0] s);
        logic [6:0] l;
        case (s)
            S_Y_MAIN:             l = L_YELLOW_MAIN;
            S_WALK:               l = L_WALK;
            S_G_SIDE, S_G_SIDE_X: l = L_GREEN_SIDE;
            S_Y_SIDE:             l = L_YELLOW_SIDE;
            default:              l = L_GREEN_MAIN;
        endcase
        return l;
    endfunction

    function automatic logic [2:0] expiry_target(input logic [2:0] s,
                                                 input logic       sensor,
                                                 input logic       walk_pending);
        logic [2:0] n;
        case (s)
            S_G_MAIN_A: n = sensor ? S_Y_MAIN : S_G_MAIN_B;
            S_G_MAIN_B: n = S_Y_MAIN;
            S_Y_MAIN:   n = walk_pending ? S_WALK : S_G_SIDE;
            S_WALK:     n = S_G_SIDE;
`ifdef TRAFFIC_SIDE_EXT_EN
            S_G_SIDE:   n = sensor ? S_G_SIDE_X : S_Y_SIDE;
            S_G_SIDE_X: n = S_Y_SIDE;
`else
            S_G_SIDE:   n = S_Y_SIDE;
`endif
            S_Y_SIDE:   n = S_G_MAIN_A;
            default:    n = S_G_MAIN_A;
        endcase
        return n;
    endfunction

    // Next-state logic; start_q marks the ARM cycle, pend_q the cycle right after reset release.
    always_comb begin
        state_d = state_q;
        pend_d  = 1'b0;
        start_d = 1'b0;
        wrr_d   = 1'b0;
        if (prog_sync) begin
            state_d = S_G_MAIN_A;
            start_d = 1'b1;
        end else if (!state_legal(state_q)) begin
            state_d = S_G_MAIN_A;
            start_d = 1'b1;
        end else if (pend_q) begin
            state_d = S_G_MAIN_A;
            start_d = 1'b1;
        end else if (start_q) begin
            state_d = state_q;
        end else if (expired) begin
            state_d = expiry_target(state_q, sensor_sync, WR);
            start_d = 1'b1;
            wrr_d   = (state_d == S_WALK);
        end else begin
            state_d = state_q;
        end
        interval_d = state_interval(state_d);
        lamps_d    = state_lamps(state_d);
    end

    // State and registered outputs; reset parks in G_MAIN_A with the timer not yet armed.
    always_ff @(posedge clk) begin
        if (sys_reset) begin
            state_q    <= S_G_MAIN_A;
            pend_q     <= 1'b1;
            start_q    <= 1'b0;
            wrr_q      <= 1'b0;
            interval_q <= IDX_BASE;
            lamps_q    <= L_GREEN_MAIN;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            start_q    <= start_d;
            wrr_q      <= wrr_d;
            interval_q <= interval_d;
            lamps_q    <= lamps_d;
        end
    end

    assign interval    = interval_q;
    assign start_timer = start_q;
    assign WR_reset    = wrr_q;
    assign {Rm, Ym, Gm, Rs, Ys, Gs, W} = lamps_q;

endmodule
